// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
//   Load bus for the 7-segment scan controller.
//   master drives the bus and the controller (slave) samples it.
//   Signals:
//     cs       load strobe, one clk wide
//     i_data   4*DIGITS hex nibbles, digit k = i_data[4k+3:4k]
//     i_dp     per-digit decimal point, 1 = lit
//     i_blank  per-digit force-dark, 1 = blank (dp also dark)
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic                  cs;
  logic [4*DIGITS-1:0]   i_data;
  logic [DIGITS-1:0]     i_dp;
  logic [DIGITS-1:0]     i_blank;

  modport master (output cs, i_data, i_dp, i_blank);
  modport slave  (input  cs, i_data, i_dp, i_blank);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Multiplexed 7-segment display driver. Holds DIGITS hex nibbles with
//   per-digit dp/blank flags, scans one digit per 2**DIV_W clk cycles, and
//   supports leading-zero suppression and tear-free frame-synchronous loading.
//   Optional brightness PWM is compiled in when SEG7_DIM_EN is defined.
// Parameters:
//   DIGITS     digits scanned (2..16)
//   DIV_W      prescaler width, one digit slot = 2**DIV_W clk cycles (>= 4)
//   SYNC_LOAD  1: loads commit at frame wrap; 0: commit on the cs clk
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   ld         load bus (slave): cs, i_data, i_dp, i_blank
//   lz_en      leading-zero suppression enable (live)
//   i_bright   PWM duty 0..15 (SEG7_DIM_EN only)
//   o_seg      active-low {dp,g,f,e,d,c,b,a}
//   o_sel      active-low one-hot digit select
//   o_frame    one-clk pulse after the scan wraps from DIGITS-1 to 0
module seg7_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int DIV_W     = 15,
  parameter bit SYNC_LOAD = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  seg7_scan_ctrl_if.slave    ld,
  input  logic               lz_en,
`ifdef SEG7_DIM_EN
  input  logic [3:0]         i_bright,
`endif
  output logic [7:0]         o_seg,
  output logic [DIGITS-1:0]  o_sel,
  output logic               o_frame
);

  localparam int AW = $clog2(DIGITS);
  localparam logic [AW-1:0] LAST = AW'(DIGITS - 1);

  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [4*DIGITS-1:0]  pend_data_q, pend_data_d;
  logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]    pend_blank_q, pend_blank_d;
  logic [4*DIGITS-1:0]  disp_data_q, disp_data_d;
  logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]    disp_blank_q, disp_blank_d;
  logic [7:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    sel_q, sel_d;
  logic                 frame_q, frame_d;

  logic                 tick;
  logic                 wrap;
  logic [DIGITS-1:0]    tail_zero;
  logic                 tz_run;
  logic [3:0]           cur_nib;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Scan timing
  always_comb begin
    tick   = &cnt_q;
    wrap   = tick && (addr_q == LAST);
    cnt_d  = cnt_q + 1'b1;
    addr_d = addr_q;
    if (tick) begin
      addr_d = wrap ? '0 : addr_q + 1'b1;
    end
    frame_d = wrap;
  end

  // Load path. In sync mode, a cs landing on the wrap clk goes straight to
  // the display so it is not delayed by a whole frame.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (SYNC_LOAD) begin
      if (ld.cs) begin
        pend_data_d  = ld.i_data;
        pend_dp_d    = ld.i_dp;
        pend_blank_d = ld.i_blank;
      end
      if (wrap) begin
        disp_data_d  = ld.cs ? ld.i_data  : pend_data_q;
        disp_dp_d    = ld.cs ? ld.i_dp    : pend_dp_q;
        disp_blank_d = ld.cs ? ld.i_blank : pend_blank_q;
      end
    end else if (ld.cs) begin
      disp_data_d  = ld.i_data;
      disp_dp_d    = ld.i_dp;
      disp_blank_d = ld.i_blank;
    end
  end

  // tail_zero[k]: digits k..DIGITS-1 are all zero, dp off and not blanked.
  always_comb begin
    tail_zero = '0;
    tz_run    = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      tz_run = tz_run & (disp_data_q[4*k +: 4] == 4'h0) & ~disp_dp_q[k] & ~disp_blank_q[k];
      tail_zero[k] = tz_run;
    end
  end

  // Output decode
  always_comb begin
    cur_nib = disp_data_q[{addr_q, 2'b00} +: 4];
    seg_d   = 8'hFF;
    if (!disp_blank_q[addr_q] && !(lz_en && (addr_q != '0) && tail_zero[addr_q])) begin
      seg_d = hex7(cur_nib);
      if (disp_dp_q[addr_q]) begin
        seg_d[7] = 1'b0;
      end
    end
`ifdef SEG7_DIM_EN
    // Duty is taken from the top prescaler bits so it spans each digit slot.
    if (cnt_q[DIV_W-1 -: 4] >= i_bright) begin
      seg_d = 8'hFF;
    end
`endif
    sel_d = ~(DIGITS'(1) << addr_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      addr_q       <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= 8'hFF;
      sel_q        <= '1;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_q      <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule
